// File: rtl/axis_scaler_ramp_ctrl.sv
// Gain sequencer: steps the scaler's signed scale factor toward a commanded target.
// Optional hold-then-mute envelope enabled by defining SCALER_RAMP_DWELL_EN.
module axis_scaler_ramp_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int CNTR_WIDTH = 32,
    parameter int INIT_SCALE = 4096
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic signed [DATA_WIDTH-1:0] cfg_target,
    input  logic        [DATA_WIDTH-1:0] cfg_step,
    input  logic        [CNTR_WIDTH-1:0] cfg_interval,
    input  logic        [CNTR_WIDTH-1:0] cfg_dwell,
    input  logic                         start,
    input  logic                         abort,
    output logic signed [DATA_WIDTH-1:0] scale_data,
    output logic                         busy,
    output logic                         done
);

    localparam int W = DATA_WIDTH;
    localparam logic signed [W-1:0] INIT_S = W'(INIT_SCALE);

`ifdef SCALER_RAMP_DWELL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, DONE = 2'd2, DWELL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t                  state_r;
    logic signed [W-1:0]     scale_r;
    logic signed [W-1:0]     tgt_r;
    logic        [W-1:0]     step_r;
    logic [CNTR_WIDTH-1:0]   intv_r;
    logic [CNTR_WIDTH-1:0]   cnt_r;
    logic                    start_prev_r;
    logic                    busy_r;
    logic                    done_r;

    logic                    edge_s;
    logic                    relatch_s;
    logic [CNTR_WIDTH-1:0]   intv_eff_s;
    logic signed [W:0]       cur_ext_s;
    logic signed [W:0]       tgt_ext_s;
    logic signed [W:0]       step_ext_s;
    logic signed [W:0]       diff_s;
    logic signed [W:0]       stepped_s;
    logic        [W:0]       mag_s;
    logic                    reach_s;
    logic                    active_s;

`ifdef SCALER_RAMP_DWELL_EN
    logic [CNTR_WIDTH-1:0]   dwell_r;
`else
    logic                    dwell_unused_s;
    assign dwell_unused_s = ^cfg_dwell;
`endif

    // Start edge, relatch qualification and one-step arithmetic at W+1 bits.
    always_comb begin
        edge_s     = start & ~start_prev_r;
        intv_eff_s = (cfg_interval == '0) ? CNTR_WIDTH'(1) : cfg_interval;
        cur_ext_s  = {scale_r[W-1], scale_r};
        tgt_ext_s  = {tgt_r[W-1], tgt_r};
        step_ext_s = {1'b0, step_r};
        diff_s     = tgt_ext_s - cur_ext_s;
        if (diff_s[W]) begin
            mag_s     = -diff_s;
            stepped_s = cur_ext_s - step_ext_s;
        end else begin
            mag_s     = diff_s;
            stepped_s = cur_ext_s + step_ext_s;
        end
        reach_s = (step_r == '0) || (mag_s <= {1'b0, step_r});
        case (state_r)
            IDLE:    active_s = 1'b0;
            RAMP:    active_s = 1'b1;
`ifdef SCALER_RAMP_DWELL_EN
            DWELL:   active_s = 1'b1;
`endif
            default: active_s = 1'b0;
        endcase
        // DONE never relatches; abort swallows a coincident edge everywhere.
        relatch_s = edge_s & ~abort & (state_r != DONE);
    end

    // Shadow copies of the command, frozen between start edges.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tgt_r   <= INIT_S;
            step_r  <= '0;
            intv_r  <= CNTR_WIDTH'(1);
`ifdef SCALER_RAMP_DWELL_EN
            dwell_r <= '0;
`endif
        end else if (relatch_s) begin
            tgt_r   <= cfg_target;
            step_r  <= cfg_step;
            intv_r  <= intv_eff_s;
`ifdef SCALER_RAMP_DWELL_EN
            dwell_r <= cfg_dwell;
`endif
        end
    end

    // Sequencer state, interval/dwell counter and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r      <= IDLE;
            scale_r      <= INIT_S;
            cnt_r        <= '0;
            start_prev_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            start_prev_r <= start;
            busy_r       <= active_s;
            done_r       <= (state_r == DONE) & ~abort;
            if (relatch_s) begin
                state_r <= RAMP;
                cnt_r   <= intv_eff_s - CNTR_WIDTH'(1);
            end else if (abort) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    RAMP: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNTR_WIDTH'(1);
                        end else if (reach_s) begin
                            scale_r <= tgt_r;
                            state_r <= DONE;
                        end else begin
                            scale_r <= stepped_s[W-1:0];
                            cnt_r   <= intv_r - CNTR_WIDTH'(1);
                        end
                    end
`ifdef SCALER_RAMP_DWELL_EN
                    DONE: begin
                        state_r <= DWELL;
                        cnt_r   <= dwell_r;
                    end
                    DWELL: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNTR_WIDTH'(1);
                        end else begin
                            scale_r <= '0;
                            state_r <= IDLE;
                        end
                    end
`else
                    DONE: state_r <= IDLE;
`endif
                    IDLE:    state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign scale_data = scale_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/axis_scaler_ramp_ctrl.md
Name: axis_scaler_ramp_ctrl

Overview:
- Gain sequencer for the AXI-Stream scaler.
- Drives the scaler's signed scale-factor input (unity = 2^(W-2), e.g. 4096 for W=14), stepping it from its present value toward a commanded target.
- Step size and step interval are programmable, giving click-free gain changes, fades and mute/unmute.
- Sits between the config register bank (cfg_* words, start/abort bits) and the scaler.

Parameters:
- DATA_WIDTH, 14, width of scale factor; must equal the scaler's data width.
- CNTR_WIDTH, 32, width of interval and dwell counters.
- INIT_SCALE, 4096, scale_data value after reset (unity for W=14).

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_target  in  DATA_WIDTH  signed target scale factor.
- cfg_step  in  DATA_WIDTH  unsigned step magnitude per update; 0 = jump directly to target.
- cfg_interval  in  CNTR_WIDTH  clocks between updates; 0 treated as 1.
- cfg_dwell  in  CNTR_WIDTH  hold time at target (used only with the optional feature).
- start  in  1  ramp command; acts on rising edge only.
- abort  in  1  level; stops ramp immediately.
- scale_data  out  DATA_WIDTH  signed scale factor to scaler cfg_data.
- busy  out  1  high while in RAMP or DWELL.
- done  out  1  one-clock pulse when target reached.

Behaviour:
- Reset (async assert, sync to aclk deassert effect):
  - scale_data=INIT_SCALE, busy=0, done=0, state=IDLE, counter=0.
  - start-edge register resets to 1, so start held high through reset release does not trigger.
- Edge detect: start_prev registered each clock; edge = start & ~start_prev.
- States: IDLE, RAMP, DONE (DWELL with the optional feature).
- IDLE, on edge:
  - Latch target, step, interval (0 -> 1) into shadow registers.
  - Load counter = interval-1; go to RAMP.
  - cfg_* changes after latch have no effect until the next edge.
- RAMP, counter != 0: decrement.
- RAMP, counter == 0: compute diff = target - scale_data at DATA_WIDTH+1 bits (no overflow).
  - If step == 0 or |diff| <= step: scale_data <= target; go to DONE.
  - Otherwise: scale_data <= scale_data ± step (sign of diff), reload counter = interval-1.
  - Never overshoots target; never wraps.
- Timing, interval=N: first update is visible on scale_data N clocks after the cycle RAMP is entered; subsequent updates every N clocks.
- DONE: done=1 for exactly one clock, then IDLE. busy=0 in DONE.
- Start edge while in RAMP (retarget): relatch shadows, reload counter, stay in RAMP; scale_data holds at its current value.
- Start edge while in DONE: ignored.
- abort=1 in any non-IDLE state: next state IDLE, scale_data frozen at current value, no done pulse.
- abort and edge in the same cycle: abort wins; the edge is consumed and discarded.
- Already at target when started: first evaluation (after interval) gives diff=0 -> DONE; scale_data unchanged, done pulses.
- busy = (state==RAMP) | (state==DWELL), registered.

Optional Feature:
- Macro: SCALER_RAMP_DWELL_EN.
- Defined:
  - From DONE go to DWELL with counter = cfg_dwell (latched at start).
  - Count down to 0, then set scale_data <= 0 immediately and return to IDLE. This produces a gated gain envelope.
  - abort in DWELL -> IDLE with scale_data held (not zeroed).
  - Start edge in DWELL -> retarget as in RAMP.
- Undefined: no DWELL state; cfg_dwell is ignored (port still present); DONE returns to IDLE.

Test Plan:
- Reset release with start held high -> no ramp; scale_data=4096, busy=0 for 20 clocks.
- target=0, step=1024, interval=4, start edge -> scale_data takes values 3072, 2048, 1024, 0, each 4 clocks apart; done pulses one clock after 0 is reached; busy falls with it.
- target=-5000, step=3000, interval=1 from 4096 -> values 1096, -1904, -4904, -5000 (last step clamped); no value beyond -5000.
- step=0, target=8191, interval=10 -> single jump to 8191 after 10 clocks, then done.
- Mid-ramp abort (target 0, step 512, abort after 2nd update) -> scale_data holds 3072, busy=0, no done. Abort and start asserted together in IDLE -> remains IDLE.
- SCALER_RAMP_DWELL_EN, dwell=8, target=2048, step=0 -> 2048 after interval, busy high through the 8-clock dwell, then scale_data=0, busy=0.
